// File: rtl/spartan_dsp_pkg.sv
// Shared widths, OPMODE bit positions and X/Z mux encodings for the DSP48A1-style slice.
package spartan_dsp_pkg;
   localparam int AB_W = 18;
   localparam int M_W  = 36;
   localparam int P_W  = 48;

   localparam int OPM_POST_SUB = 7;
   localparam int OPM_PRE_SUB  = 6;
   localparam int OPM_CIN      = 5;
   localparam int OPM_PRE_EN   = 4;

   typedef enum logic [1:0] {X_ZERO = 2'd0, X_M = 2'd1, X_P = 2'd2, X_DAB = 2'd3} xsel_e;
   typedef enum logic [1:0] {Z_ZERO = 2'd0, Z_PCIN = 2'd1, Z_P = 2'd2, Z_C = 2'd3} zsel_e;
endpackage

// File: rtl/dsp_pipe_reg.sv
// Bypassable pipeline register: sync active-high reset over clock enable; EN=0 makes it a wire.
module dsp_pipe_reg #(
   parameter int WIDTH = 18,
   parameter bit EN    = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   generate
      if (EN) begin : g_reg
         logic [WIDTH-1:0] r_q;
         always_ff @(posedge i_clk) begin
            if (i_rst)     r_q <= '0;
            else if (i_ce) r_q <= i_d;
         end
         assign o_q = r_q;
      end else begin : g_wire
         logic w_unused;
         assign w_unused = &{1'b0, i_clk, i_rst, i_ce};
         assign o_q      = i_d;
      end
   endgenerate
endmodule

// File: rtl/spartan_dsp48a1.sv
// Spartan-6 DSP48A1-style slice: pre-adder, 18x18 unsigned multiplier, 48-bit post-adder/accumulator.
// Optional elaboration-time parameter check under macro SPARTAN_DSP_PARAM_CHECK_EN.
module spartan_dsp48a1
   import spartan_dsp_pkg::*;
#(
   parameter bit    A0REG       = 1'b0,
   parameter bit    A1REG       = 1'b1,
   parameter bit    B0REG       = 1'b0,
   parameter bit    B1REG       = 1'b1,
   parameter bit    CREG        = 1'b1,
   parameter bit    DREG        = 1'b1,
   parameter bit    MREG        = 1'b1,
   parameter bit    PREG        = 1'b1,
   parameter bit    CARRYINREG  = 1'b1,
   parameter bit    CARRYOUTREG = 1'b1,
   parameter bit    OPMODEREG   = 1'b1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT",
   parameter string RSTTYPE     = "SYNC"
) (
   input  logic            i_clk,
   input  logic            i_rsta,
   input  logic            i_rstb,
   input  logic            i_rstc,
   input  logic            i_rstd,
   input  logic            i_rstm,
   input  logic            i_rstp,
   input  logic            i_rstcarryin,
   input  logic            i_rstopmode,
   input  logic            i_cea,
   input  logic            i_ceb,
   input  logic            i_cec,
   input  logic            i_ced,
   input  logic            i_cem,
   input  logic            i_cep,
   input  logic            i_cecarryin,
   input  logic            i_ceopmode,
   input  logic [AB_W-1:0] i_a,
   input  logic [AB_W-1:0] i_b,
   input  logic [AB_W-1:0] i_d,
   input  logic [AB_W-1:0] i_bcin,
   input  logic [P_W-1:0]  i_c,
   input  logic [P_W-1:0]  i_pcin,
   input  logic [7:0]      i_opmode,
   input  logic            i_carryin,
   output logic [M_W-1:0]  o_m,
   output logic [P_W-1:0]  o_p,
   output logic [P_W-1:0]  o_pcout,
   output logic [AB_W-1:0] o_bcout,
   output logic            o_carryout,
   output logic            o_carryoutf
);
`ifdef SPARTAN_DSP_PARAM_CHECK_EN
   if (CARRYINSEL != "OPMODE5" && CARRYINSEL != "CARRYIN") begin : g_bad_cinsel
      $fatal(1, "spartan_dsp48a1: illegal CARRYINSEL");
   end
   if (B_INPUT != "DIRECT" && B_INPUT != "CASCADE") begin : g_bad_binput
      $fatal(1, "spartan_dsp48a1: illegal B_INPUT");
   end
   if (RSTTYPE != "SYNC") begin : g_bad_rsttype
      $fatal(1, "spartan_dsp48a1: only RSTTYPE SYNC is supported");
   end
`endif

   // Unrecognised strings fall back to the default sources.
   localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");
   localparam bit B_FROM_CASC   = (B_INPUT == "CASCADE");

   logic [AB_W-1:0] w_a0, w_a1, w_b0, w_b1, w_d, w_pre, w_b_src, w_b1_in;
   logic [P_W-1:0]  w_c, w_x, w_z;
   logic [M_W-1:0]  w_mult;
   logic [7:0]      w_opmode;
   logic            w_cin_sel, w_cin;
   logic [P_W:0]    w_r;

   assign w_b_src = B_FROM_CASC ? i_bcin : i_b;

   dsp_pipe_reg #(.WIDTH(AB_W), .EN(A0REG)) u_a0 (.i_clk(i_clk), .i_rst(i_rsta), .i_ce(i_cea), .i_d(i_a), .o_q(w_a0));
   dsp_pipe_reg #(.WIDTH(AB_W), .EN(B0REG)) u_b0 (.i_clk(i_clk), .i_rst(i_rstb), .i_ce(i_ceb), .i_d(w_b_src), .o_q(w_b0));
   dsp_pipe_reg #(.WIDTH(AB_W), .EN(DREG))  u_d  (.i_clk(i_clk), .i_rst(i_rstd), .i_ce(i_ced), .i_d(i_d), .o_q(w_d));
   dsp_pipe_reg #(.WIDTH(P_W),  .EN(CREG))  u_c  (.i_clk(i_clk), .i_rst(i_rstc), .i_ce(i_cec), .i_d(i_c), .o_q(w_c));
   dsp_pipe_reg #(.WIDTH(8), .EN(OPMODEREG)) u_opm (.i_clk(i_clk), .i_rst(i_rstopmode), .i_ce(i_ceopmode),
                                                   .i_d(i_opmode), .o_q(w_opmode));

   assign w_pre   = w_opmode[OPM_PRE_SUB] ? w_d - w_b0 : w_d + w_b0;
   assign w_b1_in = w_opmode[OPM_PRE_EN] ? w_pre : w_b0;

   dsp_pipe_reg #(.WIDTH(AB_W), .EN(A1REG)) u_a1 (.i_clk(i_clk), .i_rst(i_rsta), .i_ce(i_cea), .i_d(w_a0), .o_q(w_a1));
   dsp_pipe_reg #(.WIDTH(AB_W), .EN(B1REG)) u_b1 (.i_clk(i_clk), .i_rst(i_rstb), .i_ce(i_ceb), .i_d(w_b1_in), .o_q(w_b1));

   assign w_mult = M_W'(w_a1) * M_W'(w_b1);

   dsp_pipe_reg #(.WIDTH(M_W), .EN(MREG)) u_m (.i_clk(i_clk), .i_rst(i_rstm), .i_ce(i_cem), .i_d(w_mult), .o_q(o_m));

   assign w_cin_sel = CIN_FROM_PORT ? i_carryin : w_opmode[OPM_CIN];

   dsp_pipe_reg #(.WIDTH(1), .EN(CARRYINREG)) u_cin (.i_clk(i_clk), .i_rst(i_rstcarryin), .i_ce(i_cecarryin),
                                                    .i_d(w_cin_sel), .o_q(w_cin));

   always_comb begin
      w_x = '0;
      case (xsel_e'(w_opmode[1:0]))
         X_ZERO: w_x = '0;
         X_M:    w_x = {{(P_W-M_W){1'b0}}, o_m};
         X_P:    w_x = o_p;
         X_DAB:  w_x = {w_d[11:0], w_a1, w_b1};
      endcase
   end

   always_comb begin
      w_z = '0;
      case (zsel_e'(w_opmode[3:2]))
         Z_ZERO: w_z = '0;
         Z_PCIN: w_z = i_pcin;
         Z_P:    w_z = o_p;
         Z_C:    w_z = w_c;
      endcase
   end

   // 49-bit post-adder so bit 48 carries out (borrow when subtracting).
   assign w_r = w_opmode[OPM_POST_SUB] ? {1'b0, w_z} - ({1'b0, w_x} + (P_W+1)'(w_cin))
                                       : {1'b0, w_z} + {1'b0, w_x} + (P_W+1)'(w_cin);

   dsp_pipe_reg #(.WIDTH(P_W), .EN(PREG)) u_p (.i_clk(i_clk), .i_rst(i_rstp), .i_ce(i_cep),
                                              .i_d(w_r[P_W-1:0]), .o_q(o_p));
   dsp_pipe_reg #(.WIDTH(1), .EN(CARRYOUTREG)) u_cout (.i_clk(i_clk), .i_rst(i_rstp), .i_ce(i_cep),
                                                      .i_d(w_r[P_W]), .o_q(o_carryout));

   assign o_pcout     = o_p;
   assign o_bcout     = w_b1;
   assign o_carryoutf = o_carryout;
endmodule

// File: tb/tb_spartan_dsp48a1.sv
// Directed-vector bench for spartan_dsp48a1 in its default configuration.
module tb_spartan_dsp48a1;
   logic        clk = 1'b0;
   logic        rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode;
   logic        cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode;
   logic [17:0] a, b, d, bcin;
   logic [47:0] c, pcin;
   logic [7:0]  opmode;
   logic        carryin;
   logic [35:0] m;
   logic [47:0] p, pcout;
   logic [17:0] bcout;
   logic        carryout, carryoutf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   spartan_dsp48a1 dut (
      .i_clk(clk), .i_rsta(rsta), .i_rstb(rstb), .i_rstc(rstc), .i_rstd(rstd),
      .i_rstm(rstm), .i_rstp(rstp), .i_rstcarryin(rstcarryin), .i_rstopmode(rstopmode),
      .i_cea(cea), .i_ceb(ceb), .i_cec(cec), .i_ced(ced), .i_cem(cem), .i_cep(cep),
      .i_cecarryin(cecarryin), .i_ceopmode(ceopmode),
      .i_a(a), .i_b(b), .i_d(d), .i_bcin(bcin), .i_c(c), .i_pcin(pcin),
      .i_opmode(opmode), .i_carryin(carryin),
      .o_m(m), .o_p(p), .o_pcout(pcout), .o_bcout(bcout),
      .o_carryout(carryout), .o_carryoutf(carryoutf)
   );

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_all_rst(input logic v);
      {rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode} = {8{v}};
   endtask

   task automatic set_all_ce(input logic v);
      {cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode} = {8{v}};
   endtask

   initial begin
      set_all_rst(1'b1);
      set_all_ce(1'b0);
      a = '0; b = '0; d = '0; bcin = 18'h3_FFFF; c = '0; pcin = 48'h1234;
      opmode = '0; carryin = 1'b1;

      // Reset with clock enables low.
      tick(4);
      check("rst_p", p, 48'd0);
      check("rst_m", 48'(m), 48'd0);
      check("rst_bcout", 48'(bcout), 48'd0);
      check("rst_cout", 48'(carryout), 48'd0);
      check("rst_pcout", pcout, 48'd0);

      // Plain multiply: X=M, Z=0.
      set_all_rst(1'b0);
      set_all_ce(1'b1);
      opmode = 8'h01; a = 18'd5; b = 18'd10;
      tick(3);
      check("mul_m", 48'(m), 48'd50);
      check("mul_p", p, 48'd50);
      check("mul_bcout", 48'(bcout), 48'd10);

      // RSTP clears only P/CARRYOUT.
      rstp = 1'b1;
      tick(4);
      check("rstp_p", p, 48'd0);
      check("rstp_cout", 48'(carryout), 48'd0);
      check("rstp_m", 48'(m), 48'd50);
      rstp = 1'b0; a = 18'd3; b = 18'd7;
      tick(3);
      check("rstp_rel_p", p, 48'd21);

      // Pre-adder D+B feeds B1, post-adder adds C.
      opmode = 8'h1D; d = 18'd18; b = 18'd10; a = 18'd5; c = 48'd40;
      tick(4);
      check("pre_bcout", 48'(bcout), 48'd28);
      check("pre_m", 48'(m), 48'd140);
      check("pre_p", p, 48'd180);

      // Subtract with OPMODE5 carry-in: 40 - (50 + 1).
      opmode = 8'hAD;
      tick(4);
      check("sub_p", p, 48'hFFFF_FFFF_FFF5);
      check("sub_cout", 48'(carryout), 48'd1);
      check("sub_coutf", 48'(carryoutf), 48'd1);
      check("sub_pcout", pcout, 48'hFFFF_FFFF_FFF5);

      // Accumulate P += M, starting from a cleared P.
      opmode = 8'h09; a = 18'd2; b = 18'd3;
      rstp = 1'b1;
      tick(3);
      check("acc_p0", p, 48'd0);
      rstp = 1'b0;
      tick(1);
      check("acc_p1", p, 48'd6);
      tick(1);
      check("acc_p2", p, 48'd12);
      tick(1);
      check("acc_p3", p, 48'd18);
      check("acc_cout", 48'(carryout), 48'd0);
      cep = 1'b0;
      tick(2);
      check("hold_p", p, 48'd18);
      check("hold_m", 48'(m), 48'd6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
